// File: rtl/spi_pkg.sv
// spi_pkg: shared types, SPI mode encodings and sizing helpers for the SPI slave.
package spi_pkg;
  typedef enum logic {IDLE, ACTIVE} spi_state_e;
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;
  localparam int SPI_WORD_W = 32;
  localparam int SPI_FIFO_DEPTH = 4;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous first-word-fall-through FIFO; a push into a full FIFO succeeds if a pop happens in the same cycle.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = wr_q == rd_q;
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  // head reads as zero while empty so reset and drained states look identical
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop) rd_q <= rd_q + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: oversampled SPI slave (all CPOL/CPHA modes) with RX/TX FIFOs and sticky error flags.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int               WORD_W     = SPI_WORD_W,
  parameter int               FIFO_DEPTH = SPI_FIFO_DEPTH,
  parameter bit               CPOL       = 1'b0,
  parameter bit               CPHA       = 1'b0,
  parameter bit               MSB_FIRST  = 1'b1,
  parameter logic [WORD_W-1:0] TX_FILL   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              cs_n,
  output logic              miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  output logic              rx_overflow,
  output logic              tx_underflow,
  output logic              frame_err,
  input  logic              status_clr
);
  localparam int CW = clog2(WORD_W);
  logic [2:0] sclk_q;
  logic [1:0] mosi_q, cs_q;
  spi_state_e state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, rx_word, tx_head, tx_word;
  logic miso_q, miso_d, skip_q, skip_d;
  logic ovf_q, ovf_d, unf_q, unf_d, ferr_q, ferr_d;
  logic lead, trail, act, smp, shf, cs_fall, cs_rise, last, load;
  logic rx_full, rx_empty, tx_full, tx_empty;
  function automatic logic hd(input logic [WORD_W-1:0] x);
    return MSB_FIRST ? x[WORD_W-1] : x[0];
  endfunction
  function automatic logic [WORD_W-1:0] shl(input logic [WORD_W-1:0] x);
    return MSB_FIRST ? {x[WORD_W-2:0], 1'b0} : {1'b0, x[WORD_W-1:1]};
  endfunction
  assign lead    = (sclk_q[1] ^ CPOL) & ~(sclk_q[2] ^ CPOL);
  assign trail   = ~(sclk_q[1] ^ CPOL) & (sclk_q[2] ^ CPOL);
  assign act     = state_q == ACTIVE && !cs_q[1];
  assign smp     = act && (CPHA ? trail : lead);
  assign shf     = act && (CPHA ? lead : trail);
  assign cs_fall = state_q == IDLE && !cs_q[1];
  assign cs_rise = state_q == ACTIVE && cs_q[1];
  assign last    = smp && bit_cnt_q == CW'(WORD_W-1);
  assign load    = cs_fall || last;
  assign rx_word = MSB_FIRST ? {rx_shift_q[WORD_W-2:0], mosi_q[1]} : {mosi_q[1], rx_shift_q[WORD_W-1:1]};
  assign tx_word = tx_empty ? TX_FILL : tx_head;
  always_comb begin
    state_d    = cs_fall ? ACTIVE : cs_rise ? IDLE : state_q;
    bit_cnt_d  = (cs_rise || last) ? '0 : smp ? bit_cnt_q + CW'(1) : bit_cnt_q;
    rx_shift_d = cs_rise ? '0 : smp ? rx_word : rx_shift_q;
    tx_shift_d = tx_shift_q;
    miso_d     = miso_q;
    skip_d     = skip_q;
    // CPHA=0 presents the first bit at load; the shift edge right after a word boundary must not advance
    if (cs_rise) begin
      miso_d = 1'b0;
      skip_d = 1'b0;
    end else if (load) begin
      tx_shift_d = CPHA ? tx_word : shl(tx_word);
      miso_d     = CPHA ? miso_q : hd(tx_word);
      skip_d     = last && !CPHA;
    end else if (shf) begin
      miso_d     = skip_q ? miso_q : hd(tx_shift_q);
      tx_shift_d = skip_q ? tx_shift_q : shl(tx_shift_q);
      skip_d     = 1'b0;
    end
    ovf_d  = (last && rx_full && !(rx_ready && !rx_empty)) ? 1'b1 : status_clr ? 1'b0 : ovf_q;
    unf_d  = (load && tx_empty) ? 1'b1 : status_clr ? 1'b0 : unf_q;
    ferr_d = (cs_rise && bit_cnt_q != '0) ? 1'b1 : status_clr ? 1'b0 : ferr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q     <= {3{CPOL}};
      mosi_q     <= '0;
      cs_q       <= '1;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      miso_q     <= 1'b0;
      skip_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sclk_q     <= {sclk_q[1:0], sclk};
      mosi_q     <= {mosi_q[0], mosi};
      cs_q       <= {cs_q[0], cs_n};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      miso_q     <= miso_d;
      skip_q     <= skip_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      ferr_q     <= ferr_d;
    end
  spi_sync_fifo #(.DATA_W(WORD_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(last), .pop(rx_ready), .din(rx_word),
    .dout(rx_data), .full(rx_full), .empty(rx_empty)
  );
  spi_sync_fifo #(.DATA_W(WORD_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid && !tx_full), .pop(load), .din(tx_data),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  assign miso         = miso_q;
  assign rx_valid     = !rx_empty;
  assign tx_ready     = !tx_full;
  assign busy         = state_q == ACTIVE;
  assign rx_overflow  = ovf_q;
  assign tx_underflow = unf_q;
  assign frame_err    = ferr_q;
endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb_spi_slave_fifo: directed scoreboard bench for a mode-0 32-bit instance and a mode-3 8-bit LSB-first instance.
module tb_spi_slave_fifo;
  localparam int H = 6;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic sclk_a = 1'b0, mosi_a = 1'b0, cs_a = 1'b1, rx_ready_a = 1'b0, tx_valid_a = 1'b0, clr_a = 1'b0;
  logic [31:0] tx_data_a = '0, rx_data_a;
  logic miso_a, rx_valid_a, tx_ready_a, busy_a, ovf_a, unf_a, ferr_a;
  logic sclk_b = 1'b1, mosi_b = 1'b0, cs_b = 1'b1, rx_ready_b = 1'b0, tx_valid_b = 1'b0, clr_b = 1'b0;
  logic [7:0] tx_data_b = '0, rx_data_b;
  logic miso_b, rx_valid_b, tx_ready_b, busy_b, ovf_b, unf_b, ferr_b;
  int vectors = 0, miscompares = 0;
  logic [31:0] rxq[$], txq[$];

  spi_slave_fifo #(.WORD_W(32), .FIFO_DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1),
                   .TX_FILL(32'hCAFE_0000)) u_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_a), .miso(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy(busy_a), .rx_overflow(ovf_a),
    .tx_underflow(unf_a), .frame_err(ferr_a), .status_clr(clr_a));

  spi_slave_fifo #(.WORD_W(8), .FIFO_DEPTH(2), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0),
                   .TX_FILL(8'hEE)) u_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_b), .miso(miso_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b), .rx_overflow(ovf_b),
    .tx_underflow(unf_b), .frame_err(ferr_b), .status_clr(clr_b));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bits_a(input logic [31:0] mo, input int n, output logic [31:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      mosi_a = mo[31-i];
      tick(H);
      mi = {mi[30:0], miso_a};
      sclk_a = 1'b1;
      tick(H);
      sclk_a = 1'b0;
    end
  endtask

  task automatic word_a(input logic [31:0] mo, input bit keep);
    logic [31:0] mi;
    bits_a(mo, 32, mi);
    if (keep) rxq.push_back(mo);
    chk("miso_word_a", mi, txq.pop_front());
  endtask

  task automatic push_a(input logic [31:0] w);
    tx_data_a = w;
    tx_valid_a = 1'b1;
    tick(1);
    tx_valid_a = 1'b0;
  endtask

  task automatic start_a();
    cs_a = 1'b0;
    tick(8);
  endtask

  task automatic end_a();
    tick(4);
    cs_a = 1'b1;
    tick(8);
  endtask

  task automatic drain_a(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!rx_valid_a && t < 20) begin
        tick(1);
        t++;
      end
      chk("rx_valid_a", rx_valid_a, 1);
      chk("rx_data_a", rx_data_a, rxq.pop_front());
      rx_ready_a = 1'b1;
      tick(1);
      rx_ready_a = 1'b0;
    end
  endtask

  task automatic bits_b(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < n; i++) begin
      tick(H);
      sclk_b = 1'b0;
      mosi_b = mo[i];
      tick(H);
      mi[i] = miso_b;
      sclk_b = 1'b1;
    end
  endtask

  task automatic push_b(input logic [7:0] w);
    tx_data_b = w;
    tx_valid_b = 1'b1;
    tick(1);
    tx_valid_b = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] mi, p0;
    logic [7:0] mb;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("reset_miso_a", miso_a, 0);
    chk("reset_rx_valid_a", rx_valid_a, 0);
    chk("reset_rx_data_a", rx_data_a, 0);
    chk("reset_tx_ready_a", tx_ready_a, 1);
    chk("reset_busy_a", busy_a, 0);
    chk("reset_flags_a", {ovf_a, unf_a, ferr_a}, 0);
    chk("reset_tx_ready_b", tx_ready_b, 1);
    chk("reset_flags_b", {ovf_b, unf_b, ferr_b}, 0);

    // mode 0 single word; a spare TX word covers the boundary reload
    push_a(32'hDEAD_BEEF);
    push_a(32'h0BAD_F00D);
    txq.push_back(32'hDEAD_BEEF);
    start_a();
    chk("busy_active_a", busy_a, 1);
    word_a(32'hA5A5_1234, 1);
    end_a();
    chk("busy_idle_a", busy_a, 0);
    drain_a(1);
    chk("flags_t1_a", {ovf_a, unf_a, ferr_a}, 0);
    chk("tx_ready_t1_a", tx_ready_a, 1);

    // back-to-back words with a full TX FIFO
    push_a(32'h0123_4567);
    push_a(32'h89AB_CDEF);
    push_a(32'h5555_AAAA);
    push_a(32'hFFFF_0000);
    chk("tx_full_a", tx_ready_a, 0);
    txq.push_back(32'h0123_4567);
    txq.push_back(32'h89AB_CDEF);
    txq.push_back(32'h5555_AAAA);
    start_a();
    word_a(32'h1, 1);
    word_a(32'h2, 1);
    word_a(32'h3, 1);
    end_a();
    drain_a(3);
    chk("flags_t2_a", {ovf_a, unf_a, ferr_a}, 0);

    // empty TX FIFO and RX overflow in one frame
    for (int i = 0; i < 5; i++) txq.push_back(32'hCAFE_0000);
    start_a();
    chk("underflow_a", unf_a, 1);
    for (int i = 0; i < 5; i++) word_a(32'h1000_0000 + 32'(i), i < 4);
    end_a();
    chk("overflow_a", ovf_a, 1);
    drain_a(4);
    tick(2);
    chk("rx_drained_a", rx_valid_a, 0);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("clr_flags_a", {ovf_a, unf_a}, 0);

    // aborted frame after 12 bits, then a clean frame
    p0 = 32'h9ABC_DEF0;
    push_a(p0);
    push_a(32'h7654_3210);
    push_a(32'h1357_9BDF);
    start_a();
    bits_a(32'hFFF0_0000, 12, mi);
    chk("miso_partial_a", mi[11:0], p0[31:20]);
    end_a();
    chk("frame_err_a", ferr_a, 1);
    chk("no_rx_push_a", rx_valid_a, 0);
    txq.push_back(32'h7654_3210);
    start_a();
    word_a(32'h0F0F_0F0F, 1);
    end_a();
    drain_a(1);
    chk("flags_t4_a", {ovf_a, unf_a, ferr_a}, 3'b001);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    chk("clr_ferr_a", ferr_a, 0);

    // mode 3, 8-bit LSB-first
    push_b(8'h3C);
    push_b(8'h55);
    chk("tx_full_b", tx_ready_b, 0);
    cs_b = 1'b0;
    tick(8);
    bits_b(8'h81, 8, mb);
    chk("miso_word_b", mb, 8'h3C);
    tick(4);
    cs_b = 1'b1;
    tick(8);
    chk("rx_valid_b", rx_valid_b, 1);
    chk("rx_data_b", rx_data_b, 8'h81);
    chk("flags_b", {ovf_b, unf_b, ferr_b}, 0);

    // reset mid-word with data held in both FIFOs
    push_b(8'h11);
    push_b(8'h22);
    chk("tx_full2_b", tx_ready_b, 0);
    cs_b = 1'b0;
    tick(8);
    chk("busy_b", busy_b, 1);
    bits_b(8'h05, 3, mb);
    rst_n = 1'b0;
    #1;
    chk("rst_miso_b", miso_b, 0);
    chk("rst_rx_valid_b", rx_valid_b, 0);
    chk("rst_rx_data_b", rx_data_b, 0);
    chk("rst_tx_ready_b", tx_ready_b, 1);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_flags_b", {ovf_b, unf_b, ferr_b}, 0);
    cs_b = 1'b1;
    sclk_b = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    chk("post_rst_flags_b", {ovf_b, unf_b, ferr_b}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
